// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: UART transmitter with an input FIFO and a clock-enable baud
// counter running on the system clock. Frame: start bit, DATA_BITS data bits
// LSB first, optional parity bit, STOP_BITS stop bits.
// Build option: define UART_TX_PARITY_EN to insert a parity bit per frame.
module uart_tx_fifo #(
   parameter int CLOCK_FREQ = 10000000,
   parameter int BAUD_RATE  = 9600,
   parameter int DATA_BITS  = 8,
   parameter int STOP_BITS  = 1,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        tx_valid,
   input  logic [DATA_BITS-1:0]        tx_data,
   output logic                        tx_ready,
   input  logic                        parity_odd,
   output logic                        tx,
   output logic                        tx_done,
   output logic                        busy,
   output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

   localparam int CLKS_PER_BIT = CLOCK_FREQ / BAUD_RATE;
   localparam int BAUD_W       = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int PTR_W        = $clog2(FIFO_DEPTH);
   localparam int CNT_W        = $clog2(DATA_BITS + 1);

   localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0]  DATA_LAST = CNT_W'(DATA_BITS - 1);
   localparam logic [CNT_W-1:0]  STOP_LAST = CNT_W'(STOP_BITS - 1);
   localparam logic [PTR_W:0]    DEPTH_C   = (PTR_W + 1)'(FIFO_DEPTH);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
      S_PARITY = 3'd3,
`endif
      S_STOP   = 3'd4
   } state_t;

   // FIFO storage and control
   logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
   logic [PTR_W-1:0]     wr_ptr;
   logic [PTR_W-1:0]     rd_ptr;
   logic [PTR_W:0]       count_q;
   logic                 ready_q;
   logic                 full;
   logic                 empty;
   logic                 push;
   logic                 pop;

   // Serialiser state
   state_t               state_q;
   state_t               state_d;
   logic [BAUD_W-1:0]    baud_q;
   logic [BAUD_W-1:0]    baud_d;
   logic [CNT_W-1:0]     bit_q;
   logic [CNT_W-1:0]     bit_d;
   logic [DATA_BITS-1:0] shift_q;
   logic                 shift_en;
   logic                 tx_q;
   logic                 tx_d;
   logic                 done_q;
   logic                 done_d;
   logic                 bit_end;

`ifdef UART_TX_PARITY_EN
   logic                 par_q;

   // Even parity of the word, inverted when odd parity is selected.
   function automatic logic parity_bit(input logic [DATA_BITS-1:0] d,
                                       input logic                 odd);
      return (^d) ^ odd;
   endfunction
`else
   // Parity select has no effect when no parity bit is transmitted.
   logic                 unused_parity_odd;
   assign unused_parity_odd = parity_odd;
`endif

   assign full       = (count_q == DEPTH_C);
   assign empty      = (count_q == '0);
   assign tx_ready   = ready_q & ~full;
   assign push       = tx_valid & tx_ready;
   assign bit_end    = (baud_q == BAUD_LAST);

   assign tx         = tx_q;
   assign tx_done    = done_q;
   assign busy       = (state_q != S_IDLE);
   assign fifo_count = count_q;

   // FIFO pointers, occupancy and the post-reset ready flag.
   always_ff @(posedge clk) begin
      if (!rst) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count_q <= '0;
         ready_q <= 1'b0;
      end else begin
         ready_q <= 1'b1;
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         case ({push, pop})
            2'b10:   count_q <= count_q + (PTR_W + 1)'(1);
            2'b01:   count_q <= count_q - (PTR_W + 1)'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   // FIFO storage write; contents are don't-care until a push lands.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= tx_data;
   end

   // Shift register (and parity) load on pop, right shift per data bit.
   always_ff @(posedge clk) begin
      if (pop) begin
         shift_q <= mem[rd_ptr];
`ifdef UART_TX_PARITY_EN
         par_q   <= parity_bit(mem[rd_ptr], parity_odd);
`endif
      end else if (shift_en) begin
         shift_q <= shift_q >> 1;
      end
   end

   // FSM state, baud/bit counters and registered line outputs.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= S_IDLE;
         baud_q  <= '0;
         bit_q   <= '0;
         tx_q    <= 1'b1;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         baud_q  <= baud_d;
         bit_q   <= bit_d;
         tx_q    <= tx_d;
         done_q  <= done_d;
      end
   end

   // Next-state logic; tx_d is the line level for the coming cycle, so a
   // transition edge both changes state and drives the new bit.
   always_comb begin
      state_d  = state_q;
      baud_d   = bit_end ? '0 : baud_q + BAUD_W'(1);
      bit_d    = bit_q;
      tx_d     = tx_q;
      done_d   = 1'b0;
      pop      = 1'b0;
      shift_en = 1'b0;
      case (state_q)
         S_IDLE: begin
            baud_d = '0;
            tx_d   = 1'b1;
            if (!empty) begin
               pop     = 1'b1;
               state_d = S_START;
               tx_d    = 1'b0;
            end
         end
         S_START: begin
            if (bit_end) begin
               state_d = S_DATA;
               bit_d   = '0;
               tx_d    = shift_q[0];
            end
         end
         S_DATA: begin
            if (bit_end) begin
               if (bit_q == DATA_LAST) begin
                  bit_d   = '0;
`ifdef UART_TX_PARITY_EN
                  state_d = S_PARITY;
                  tx_d    = par_q;
`else
                  state_d = S_STOP;
                  tx_d    = 1'b1;
`endif
               end else begin
                  bit_d    = bit_q + CNT_W'(1);
                  shift_en = 1'b1;
                  tx_d     = shift_q[1];
               end
            end
         end
`ifdef UART_TX_PARITY_EN
         S_PARITY: begin
            if (bit_end) begin
               state_d = S_STOP;
               bit_d   = '0;
               tx_d    = 1'b1;
            end
         end
`endif
         S_STOP: begin
            if (bit_end) begin
               if (bit_q == STOP_LAST) begin
                  done_d = 1'b1;
                  bit_d  = '0;
                  // Chain straight into the next start bit when more is queued.
                  if (!empty) begin
                     pop     = 1'b1;
                     state_d = S_START;
                     tx_d    = 1'b0;
                  end else begin
                     state_d = S_IDLE;
                     tx_d    = 1'b1;
                  end
               end else begin
                  bit_d = bit_q + CNT_W'(1);
               end
            end
         end
         default: begin
            state_d = S_IDLE;
            tx_d    = 1'b1;
         end
      endcase
   end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: directed bench for uart_tx_fifo at 10 clocks per bit.
// Instance dut is 8 data bits / 1 stop bit, instance dut5 is 5 data bits /
// 2 stop bits. Expected frames follow the UART_TX_PARITY_EN build option.
module tb_uart_tx_fifo;

   localparam int CF = 1000000;
   localparam int BR = 100000;
`ifdef UART_TX_PARITY_EN
   localparam int NB8 = 11;
   localparam int NB5 = 9;
   localparam logic [15:0] EXP_A5 = 16'h054A;
   localparam logic [15:0] EXP_1F = 16'h01FE;
`else
   localparam int NB8 = 10;
   localparam int NB5 = 8;
   localparam logic [15:0] EXP_A5 = 16'h034A;
   localparam logic [15:0] EXP_1F = 16'h00FE;
`endif
   localparam int FL = NB8 * 10;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       tx_valid = 1'b0;
   logic [7:0] tx_data = 8'h00;
   logic       parity_odd = 1'b0;
   logic       tx_ready, tx, tx_done, busy;
   logic [2:0] fifo_count;
   logic       v5 = 1'b0;
   logic [4:0] d5 = 5'h00;
   logic       rdy5, tx5, done5, busy5;
   logic [2:0] cnt5;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   uart_tx_fifo #(.CLOCK_FREQ(CF), .BAUD_RATE(BR), .DATA_BITS(8),
                  .STOP_BITS(1), .FIFO_DEPTH(4)) dut (
      .clk(clk), .rst(rst), .tx_valid(tx_valid), .tx_data(tx_data),
      .tx_ready(tx_ready), .parity_odd(parity_odd), .tx(tx),
      .tx_done(tx_done), .busy(busy), .fifo_count(fifo_count));

   uart_tx_fifo #(.CLOCK_FREQ(CF), .BAUD_RATE(BR), .DATA_BITS(5),
                  .STOP_BITS(2), .FIFO_DEPTH(4)) dut5 (
      .clk(clk), .rst(rst), .tx_valid(v5), .tx_data(d5),
      .tx_ready(rdy5), .parity_odd(parity_odd), .tx(tx5),
      .tx_done(done5), .busy(busy5), .fifo_count(cnt5));

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Expected 8-bit frame, bit 0 = start bit.
   function automatic logic [15:0] frame8(input logic [7:0] d, input logic odd);
      logic [15:0] f;
      f = '0;
      f[8:1] = d;
`ifdef UART_TX_PARITY_EN
      f[9]  = (^d) ^ odd;
      f[10] = 1'b1;
`else
      f[9]  = 1'b1;
`endif
      return f;
   endfunction

   // Samples nbits bit times (10 cycles each), starting at the first cycle
   // of a start bit: first-cycle level per bit, off-level cycles, done pulses.
   task automatic capture(input int sel, input int nbits, output logic [15:0] bits,
                          output int unstable, output int dones);
      logic cur;
      bits = '0;
      unstable = 0;
      dones = 0;
      for (int k = 0; k < nbits; k++) begin
         for (int c = 0; c < 10; c++) begin
            cur = (sel == 0) ? tx : tx5;
            if (c == 0) bits[k] = cur;
            else if (cur !== bits[k]) unstable++;
            if (((sel == 0) ? tx_done : done5) === 1'b1) dones++;
            tick(1);
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b0; tx_valid = 1'b0; v5 = 1'b0;
      tick(3);
      checks++; if (tx !== 1'b1) begin failures++; $display("FAIL reset_tx actual=%b required=1", tx); end
      checks++; if (tx_done !== 1'b0) begin failures++; $display("FAIL reset_done actual=%b required=0", tx_done); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy actual=%b required=0", busy); end
      checks++; if (fifo_count !== 3'd0) begin failures++; $display("FAIL reset_count actual=%0d required=0", fifo_count); end
      checks++; if (tx_ready !== 1'b0) begin failures++; $display("FAIL reset_ready actual=%b required=0", tx_ready); end
      checks++; if (tx5 !== 1'b1 || busy5 !== 1'b0 || cnt5 !== 3'd0 || rdy5 !== 1'b0) begin
         failures++; $display("FAIL reset_dut5 tx=%b busy=%b count=%0d ready=%b required 1,0,0,0", tx5, busy5, cnt5, rdy5); end
      rst = 1'b1;
      tick(1);
      checks++; if (tx_ready !== 1'b1) begin failures++; $display("FAIL release_ready actual=%b required=1", tx_ready); end
      checks++; if (rdy5 !== 1'b1) begin failures++; $display("FAIL release_ready5 actual=%b required=1", rdy5); end
      checks++; if (tx !== 1'b1) begin failures++; $display("FAIL release_tx actual=%b required=1", tx); end
   endtask

   task automatic test_8n1();
      logic [15:0] bits;
      int unst, dn;
      parity_odd = 1'b0;
      tx_data = 8'hA5; tx_valid = 1'b1;
      tick(1);
      tx_valid = 1'b0;
      checks++; if (tx !== 1'b1) begin failures++; $display("FAIL push_edge_tx actual=%b required=1", tx); end
      checks++; if (fifo_count !== 3'd1) begin failures++; $display("FAIL push_count actual=%0d required=1", fifo_count); end
      tick(1);
      checks++; if (busy !== 1'b1 || fifo_count !== 3'd0) begin
         failures++; $display("FAIL pop_state busy=%b count=%0d required 1,0", busy, fifo_count); end
      capture(0, NB8, bits, unst, dn);
      checks++; if (bits !== EXP_A5) begin failures++; $display("FAIL frame_a5 actual=%h required=%h", bits, EXP_A5); end
      checks++; if (unst !== 0) begin failures++; $display("FAIL frame_a5_bit_timing off_cycles=%0d required=0", unst); end
      checks++; if (dn !== 0) begin failures++; $display("FAIL frame_a5_early_done pulses=%0d required=0", dn); end
      checks++; if (tx_done !== 1'b1) begin failures++; $display("FAIL frame_a5_done actual=%b required=1", tx_done); end
      checks++; if (busy !== 1'b0 || fifo_count !== 3'd0 || tx !== 1'b1) begin
         failures++; $display("FAIL frame_a5_end busy=%b count=%0d tx=%b required 0,0,1", busy, fifo_count, tx); end
      tick(1);
      checks++; if (tx_done !== 1'b0) begin failures++; $display("FAIL done_width actual=%b required=0", tx_done); end
   endtask

`ifdef UART_TX_PARITY_EN
   task automatic test_parity();
      logic [15:0] bits;
      logic [15:0] exp_f [2];
      int unst, dn;
      exp_f[0] = 16'h060E;
      exp_f[1] = 16'h040E;
      for (int i = 0; i < 2; i++) begin
         parity_odd = (i == 1);
         tx_data = 8'h07; tx_valid = 1'b1;
         tick(1);
         tx_valid = 1'b0;
         tick(1);
         capture(0, 11, bits, unst, dn);
         checks++; if (bits !== exp_f[i]) begin failures++; $display("FAIL parity_frame_%0d actual=%h required=%h", i, bits, exp_f[i]); end
         checks++; if (unst !== 0 || dn !== 0) begin failures++; $display("FAIL parity_timing_%0d off=%0d dones=%0d required 0,0", i, unst, dn); end
         checks++; if (tx_done !== 1'b1) begin failures++; $display("FAIL parity_done_%0d actual=%b required=1", i, tx_done); end
         tick(1);
      end
      parity_odd = 1'b0;
   endtask
`else
   task automatic test_parity_ignored();
      logic [15:0] bits;
      int unst, dn;
      parity_odd = 1'b1;
      tx_data = 8'h07; tx_valid = 1'b1;
      tick(1);
      tx_valid = 1'b0;
      tick(1);
      capture(0, 10, bits, unst, dn);
      checks++; if (bits !== 16'h020E) begin failures++; $display("FAIL noparity_frame actual=%h required=020e", bits); end
      checks++; if (unst !== 0 || dn !== 0) begin failures++; $display("FAIL noparity_timing off=%0d dones=%0d required 0,0", unst, dn); end
      checks++; if (tx_done !== 1'b1) begin failures++; $display("FAIL noparity_done actual=%b required=1", tx_done); end
      tick(1);
      parity_odd = 1'b0;
   endtask
`endif

   task automatic test_back_to_back();
      logic [7:0]  d [6];
      logic [5:0]  rdy_vec;
      logic        txlog [600];
      logic        donelog [600];
      logic [15:0] fr;
      logic        e, ed;
      int          tx_bad, done_bad, npulse, f;
      d[0] = 8'h11; d[1] = 8'h22; d[2] = 8'h33; d[3] = 8'h44; d[4] = 8'h55; d[5] = 8'h66;
      for (int i = 0; i < 6; i++) begin
         tx_data = d[i]; tx_valid = 1'b1;
         rdy_vec[i] = tx_ready;
         tick(1);
         txlog[i+1] = tx; donelog[i+1] = tx_done;
      end
      tx_valid = 1'b0;
      checks++; if (rdy_vec !== 6'b011111) begin failures++; $display("FAIL burst_ready actual=%b required=011111", rdy_vec); end
      checks++; if (fifo_count !== 3'd4) begin failures++; $display("FAIL burst_count actual=%0d required=4", fifo_count); end
      for (int s = 7; s < 600; s++) begin
         tick(1);
         txlog[s] = tx; donelog[s] = tx_done;
      end
      tx_bad = 0; done_bad = 0; npulse = 0;
      for (int s = 1; s < 600; s++) begin
         e = 1'b1;
         ed = 1'b0;
         if (s >= 2) begin
            f = (s - 2) / FL;
            if (f < 5) begin
               fr = frame8(d[f], 1'b0);
               e = fr[((s - 2) % FL) / 10];
            end
            ed = (s > 2) && ((s - 2) % FL == 0) && (f <= 5);
         end
         if (txlog[s] !== e) tx_bad++;
         if (donelog[s] !== ed) done_bad++;
         if (donelog[s] === 1'b1) npulse++;
      end
      checks++; if (tx_bad !== 0) begin failures++; $display("FAIL burst_line wrong_cycles=%0d required=0", tx_bad); end
      checks++; if (txlog[2+FL] !== 1'b0) begin failures++; $display("FAIL burst_no_gap actual=%b required=0", txlog[2+FL]); end
      checks++; if (done_bad !== 0) begin failures++; $display("FAIL burst_done_timing wrong_cycles=%0d required=0", done_bad); end
      checks++; if (npulse !== 5) begin failures++; $display("FAIL burst_done_count actual=%0d required=5", npulse); end
      checks++; if (busy !== 1'b0 || fifo_count !== 3'd0) begin
         failures++; $display("FAIL burst_end busy=%b count=%0d required 0,0", busy, fifo_count); end
   endtask

   task automatic test_5bit_2stop();
      logic [15:0] bits;
      int unst, dn, low;
      d5 = 5'h1F; v5 = 1'b1;
      tick(1);
      v5 = 1'b0;
      tick(1);
      capture(1, NB5, bits, unst, dn);
      checks++; if (bits !== EXP_1F) begin failures++; $display("FAIL frame5 actual=%h required=%h", bits, EXP_1F); end
      checks++; if (unst !== 0 || dn !== 0) begin failures++; $display("FAIL frame5_timing off=%0d dones=%0d required 0,0", unst, dn); end
      checks++; if (done5 !== 1'b1 || busy5 !== 1'b0) begin
         failures++; $display("FAIL frame5_end done=%b busy=%b required 1,0", done5, busy5); end
      low = 0;
      for (int c = 0; c < 30; c++) begin
         tick(1);
         if (tx5 !== 1'b1 || done5 !== 1'b0) low++;
      end
      checks++; if (low !== 0) begin failures++; $display("FAIL frame5_idle_line bad_cycles=%0d required=0", low); end
   endtask

   task automatic test_reset_mid_frame();
      int low, dn;
      tx_data = 8'hA5; tx_valid = 1'b1;
      tick(1);
      tx_data = 8'h3C;
      tick(1);
      tx_data = 8'h81;
      tick(1);
      tx_valid = 1'b0;
      checks++; if (fifo_count !== 3'd2) begin failures++; $display("FAIL midrst_queued actual=%0d required=2", fifo_count); end
      tick(42);
      checks++; if (tx !== 1'b0 || busy !== 1'b1) begin
         failures++; $display("FAIL midrst_data_bit3 tx=%b busy=%b required 0,1", tx, busy); end
      rst = 1'b0;
      tick(1);
      checks++; if (tx !== 1'b1 || busy !== 1'b0) begin
         failures++; $display("FAIL midrst_abort tx=%b busy=%b required 1,0", tx, busy); end
      checks++; if (fifo_count !== 3'd0 || tx_done !== 1'b0) begin
         failures++; $display("FAIL midrst_flush count=%0d done=%b required 0,0", fifo_count, tx_done); end
      tick(1);
      checks++; if (tx_ready !== 1'b0) begin failures++; $display("FAIL midrst_ready actual=%b required=0", tx_ready); end
      rst = 1'b1;
      low = 0; dn = 0;
      for (int c = 0; c < 300; c++) begin
         tick(1);
         if (tx !== 1'b1) low++;
         if (tx_done === 1'b1) dn++;
      end
      checks++; if (low !== 0 || dn !== 0) begin
         failures++; $display("FAIL midrst_after low_cycles=%0d dones=%0d required 0,0", low, dn); end
      checks++; if (tx_ready !== 1'b1 || busy !== 1'b0) begin
         failures++; $display("FAIL midrst_release ready=%b busy=%b required 1,0", tx_ready, busy); end
   endtask

   initial begin
      test_reset();
      test_8n1();
`ifdef UART_TX_PARITY_EN
      test_parity();
`else
      test_parity_ignored();
`endif
      test_back_to_back();
      test_5bit_2stop();
      test_reset_mid_frame();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
